// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Registers one operation per handshake onto the ALU inputs, waits
//               one settle cycle, then captures the result and flags and holds
//               them for a downstream handshake. An accumulator can replace a.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int WIDTH   = 5,
  parameter int CTRL_W  = 3,
  parameter int SHIFT_W = 2,
  parameter int FLAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [SHIFT_W-1:0] in_bshift,
  input  logic               in_lorr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               in_acc,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [SHIFT_W-1:0] alu_bshift,
  output logic               alu_lorr,
  output logic [CTRL_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [FLAG_W-1:0]  alu_flag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [FLAG_W-1:0]  out_flag,
  output logic [WIDTH-1:0]   acc,
  output logic               busy
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_exec = 2'd1;
  localparam logic [1:0] c_hold = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (in_valid)  w_next_state = c_exec;
      c_exec:                 w_next_state = c_hold;
      c_hold:  if (out_ready) w_next_state = c_idle;
      default:                w_next_state = c_idle;
    endcase
  end

  always_comb begin
    in_ready = (r_state == c_idle);
    busy     = (r_state != c_idle);
  end

  assign w_accept = (r_state == c_idle) && in_valid;

  // ALU inputs change only on accept so they stay stable through EXEC and HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_bshift <= '0;
      alu_lorr   <= 1'b0;
      alu_ctrl   <= '0;
    end else if (w_accept) begin
      alu_a      <= in_acc ? acc : in_a;
      alu_b      <= in_b;
      alu_bshift <= in_bshift;
      alu_lorr   <= in_lorr;
      alu_ctrl   <= in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flag   <= '0;
      acc        <= '0;
    end else begin
      if (r_state == c_exec) begin
        out_result <= alu_result;
        out_flag   <= alu_flag;
        acc        <= alu_result;
        out_valid  <= 1'b1;
      end else if ((r_state == c_hold) && out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench with a stand-in ALU and a transaction-level
//               reference model of the issue/capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_lorr, in_acc;
  logic [4:0] in_a, in_b;
  logic [1:0] in_bshift;
  logic [2:0] in_ctrl;
  logic [4:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_bshift;
  logic       alu_lorr;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_flag;
  logic       out_valid, out_ready, busy;
  logic [4:0] out_result, acc;
  logic [3:0] out_flag;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [4:0] acc_m = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] alu_fn(input logic [4:0] a, input logic [4:0] b,
                                        input logic [1:0] bs, input logic lorr,
                                        input logic [2:0] ctrl);
    logic [4:0] bb;
    bb = lorr ? (b << bs) : (b >> bs);
    case (ctrl)
      3'd0:    return a + bb;
      3'd1:    return a - bb;
      3'd2:    return a & bb;
      3'd3:    return a | bb;
      3'd4:    return a ^ bb;
      3'd5:    return ~a;
      3'd6:    return (a < bb) ? 5'd1 : 5'd0;
      default: return bb;
    endcase
  endfunction

  function automatic logic [3:0] flag_fn(input logic [4:0] r, input logic [2:0] ctrl);
    return {r == 5'd0, r[4], ^r, ctrl[0]};
  endfunction

  // Stand-in combinational ALU
  assign alu_result = alu_fn(alu_a, alu_b, alu_bshift, alu_lorr, alu_ctrl);
  assign alu_flag   = flag_fn(alu_result, alu_ctrl);

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bshift(in_bshift), .in_lorr(in_lorr),
    .in_ctrl(in_ctrl), .in_acc(in_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_bshift(alu_bshift), .alu_lorr(alu_lorr),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flag(alu_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flag(out_flag), .acc(acc), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [1:0] bs,
                       input logic lorr, input logic [2:0] ctrl, input logic ua);
    in_a = a; in_b = b; in_bshift = bs; in_lorr = lorr; in_ctrl = ctrl; in_acc = ua;
    in_valid = 1'b1;
  endtask

  // Wait (bounded) for an accept, then check the issued operands and EXEC status.
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [1:0] bs,
                       input logic lorr, input logic [2:0] ctrl, input logic ua,
                       input logic drop_valid, output logic [4:0] ea);
    int n;
    drive(a, b, bs, lorr, ctrl, ua);
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    ea = ua ? acc_m : a;
    step();
    if (drop_valid) in_valid = 1'b0;
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, b);
    chk("alu_bshift", alu_bshift, bs);
    chk("alu_lorr", alu_lorr, lorr);
    chk("alu_ctrl", alu_ctrl, ctrl);
    chk("exec_busy", busy, 1);
    chk("exec_in_ready", in_ready, 0);
    chk("exec_out_valid", out_valid, 0);
  endtask

  task automatic capture(input logic [4:0] ea, input logic [4:0] b, input logic [1:0] bs,
                         input logic lorr, input logic [2:0] ctrl);
    logic [4:0] r;
    r = alu_fn(ea, b, bs, lorr, ctrl);
    step();
    chk("cap_out_valid", out_valid, 1);
    chk("cap_out_result", out_result, r);
    chk("cap_out_flag", out_flag, flag_fn(r, ctrl));
    chk("cap_acc", acc, r);
    chk("cap_busy", busy, 1);
    acc_m = r;
  endtask

  task automatic hold_release(input int hold);
    logic [4:0] r;
    logic [3:0] f;
    r = out_result;
    f = out_flag;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_result", out_result, acc_m);
      chk("hold_out_flag", out_flag, f);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_result_kept", out_result, r);
    out_ready = 1'b0;
  endtask

  task automatic txn(input logic [4:0] a, input logic [4:0] b, input logic [1:0] bs,
                     input logic lorr, input logic [2:0] ctrl, input logic ua, input int hold);
    logic [4:0] ea;
    issue(a, b, bs, lorr, ctrl, ua, 1'b1, ea);
    capture(ea, b, bs, lorr, ctrl);
    hold_release(hold);
  endtask

  initial begin
    logic [4:0] ea, ra, rb;
    logic [1:0] rbs;
    logic       rl, ru;
    logic [2:0] rc;
    int         prev, n;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_bshift = '0; in_lorr = 1'b0; in_ctrl = '0; in_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single add, then accumulate chain
    txn(5'd3, 5'd5, 2'd0, 1'b0, 3'd0, 1'b0, 0);
    chk("add_acc", acc, 5'd8);
    txn(5'd0, 5'd2, 2'd0, 1'b0, 3'd0, 1'b1, 0);
    chk("chain_result", out_result, 5'd10);

    // Shift passthrough, both directions
    txn(5'd2, 5'd2, 2'd2, 1'b1, 3'd0, 1'b0, 1);
    txn(5'd2, 5'd2, 2'd2, 1'b0, 3'd0, 1'b0, 1);

    // Backpressure with a second request waiting on in_valid
    issue(5'd8, 5'd1, 2'd0, 1'b0, 3'd2, 1'b0, 1'b1, ea);
    capture(ea, 5'd1, 2'd0, 1'b0, 3'd2);
    drive(5'd7, 5'd3, 2'd0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_result", out_result, 5'd0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_a", alu_a, 5'd8);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_rel_out_valid", out_valid, 0);
    chk("bp_not_yet_accepted", alu_a, 5'd8);
    step();
    in_valid = 1'b0;
    chk("bp_second_accept_a", alu_a, 5'd7);
    chk("bp_second_busy", busy, 1);
    capture(5'd7, 5'd3, 2'd0, 1'b0, 3'd0);
    hold_release(0);

    // Asynchronous reset while holding a result
    issue(5'd9, 5'd4, 2'd1, 1'b1, 3'd3, 1'b0, 1'b1, ea);
    capture(ea, 5'd4, 2'd1, 1'b1, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_acc", acc, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_alu_ctrl", alu_ctrl, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    acc_m = '0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // Back-to-back throughput with out_ready held high
    out_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      ra = 5'($urandom); rb = 5'($urandom); rbs = 2'($urandom);
      rl = 1'($urandom); rc = 3'($urandom); ru = 1'($urandom);
      drive(ra, rb, rbs, rl, rc, ru);
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      chk("tp_ready", in_ready, 1);
      ea = ru ? acc_m : ra;
      step();
      if (k > 0) chk("tp_spacing", cyc - prev, 3);
      prev = cyc;
      chk("tp_alu_a", alu_a, ea);
      capture(ea, rb, rbs, rl, rc);
      step();
      chk("tp_pulse_end", out_valid, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Randomized transactions with random hold lengths
    for (int t = 0; t < 30; t++) begin
      txn(5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom), 3'($urandom),
          1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Operand issue and result capture stage that sits directly upstream of the 5-bit ALU top and also consumes its outputs. It accepts one operation per valid/ready handshake, registers the operands and drives them onto the ALU's combinational inputs. After a fixed settle cycle it captures the result and flags and presents them downstream on a second valid/ready handshake. An accumulator option lets chained operations use the previous result as operand a.

Parameters:
WIDTH, 5, operand/result width (matches ALU a, b, Result)
CTRL_W, 3, ALU control code width
SHIFT_W, 2, shift amount width (bshift)
FLAG_W, 4, ALU flag width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready at clk edge
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
in_bshift  in  SHIFT_W  shift amount for b
in_lorr  in  1  shift direction (1 = left, 0 = right, passed through)
in_ctrl  in  CTRL_W  ALU control code
in_acc  in  1  1 = use accumulator in place of in_a
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_bshift  out  SHIFT_W  to ALU bshift
alu_lorr  out  1  to ALU lorr
alu_ctrl  out  CTRL_W  to ALU ALUControl
alu_result  in  WIDTH  from ALU Result
alu_flag  in  FLAG_W  from ALU ALUFlag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  WIDTH  captured result
out_flag  out  FLAG_W  captured flags
acc  out  WIDTH  accumulator value (last captured result)
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values (asynchronous, immediate): state = IDLE; all alu_* outputs = 0; out_valid = 0; out_result = 0; out_flag = 0; acc = 0; busy = 0; in_ready = 1.
- FSM states: IDLE, EXEC, HOLD. All outputs are registered except in_ready and busy, which decode the state.
- IDLE:
  - in_ready = 1.
  - On an in_valid edge, register the operands: alu_a = in_acc ? acc : in_a; alu_b = in_b; alu_bshift = in_bshift; alu_lorr = in_lorr; alu_ctrl = in_ctrl. Go to EXEC.
- EXEC (exactly one cycle, ALU settle):
  - in_ready = 0.
  - At the closing edge, set out_result = alu_result, out_flag = alu_flag, acc = alu_result and out_valid = 1. Go to HOLD.
- HOLD:
  - out_valid = 1; out_result and out_flag stay stable.
  - On an edge with out_ready = 1, clear out_valid and go to IDLE.
  - While out_ready = 0, stay in HOLD indefinitely.
- The alu_* outputs keep their last issued values outside IDLE-accept edges, so ALU inputs stay stable for the whole EXEC and HOLD period.
- Latency: request accepted at edge N, out_valid high after edge N+1, captured at the end of EXEC. Minimum cycles between accepts is 3, with out_ready tied high.
- in_ready = 0 in EXEC and HOLD. A request presented then is not consumed, and the upstream must hold it.
- acc updates only on capture. in_acc at accept uses the acc value from before that accept.
- Widths: no extension or truncation. The block passes the ALU's WIDTH-bit result and flags through unmodified.
- Reset mid-operation (EXEC or HOLD): any pending result is discarded, out_valid drops immediately, acc returns to 0.
- in_valid in HOLD together with an out_ready handshake: the transition to IDLE happens first, and the request is accepted on the following edge, not the same one.

Test Plan:
- Reset then single add: rst_n low 2 cycles -> all outputs 0, in_ready = 1. Send a=3, b=5, ctrl=000, out_ready=1 -> out_valid pulses 1 cycle after edge N+1 with out_result = 8, acc = 8, busy high for 2 cycles.
- Backpressure: a=8, b=1, ctrl=010 with out_ready=0 for 5 cycles -> out_valid and out_result held stable, in_ready = 0 throughout. A second request held on in_valid is not accepted until 1 edge after out_ready rises.
- Accumulate chain: a=3, b=5, ctrl=000, then in_acc=1, b=2, ctrl=000 -> second alu_a = 8, out_result = 10, acc = 10.
- Shift passthrough: a=2, b=2, bshift=2, lorr=1, then lorr=0 -> alu_bshift = 2 and alu_lorr track each request. out_result equals the ALU model's output for each, captured 1 cycle after accept.
- Async reset in HOLD: assert rst_n mid-cycle while out_valid=1 -> out_valid, acc and alu_* clear before the next clk edge; state = IDLE.
- Back-to-back throughput: 4 requests with in_valid and out_ready held high -> accepts spaced exactly 3 cycles apart, 4 results in order, no drops or duplicates.
